acc_alu_unit: RTL and testbench

ACC_ALU_UNIT -- requirements
Module: acc_alu_unit

---
 rtl/acc_alu_unit_if.sv | 30 +++
 rtl/acc_alu_unit.sv | 104 ++++++++++
 tb/tb_acc_alu_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/acc_alu_unit_if.sv
// acc_alu_unit_if: control, data and status bundle for the accumulator/ALU unit.
// The master side (the controller) drives the load controls, the ALU operation,
// the data bus, the skip request and the current PC.
// The slave side (the unit) returns the accumulator, ALU result, flags and next PC.
interface acc_alu_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              regWrite;
  logic              ALUToACC;
  logic [1:0]        ALU_Op;
  logic [DATA_W-1:0] data;
  logic              skip;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] next_address;
  logic [DATA_W-1:0] acc_out;
  logic [DATA_W-1:0] alu_out;
  logic              isZero;
  logic              carry;

  modport master (
    output regWrite, ALUToACC, ALU_Op, data, skip, address,
    input  next_address, acc_out, alu_out, isZero, carry
  );

  modport slave (
    input  regWrite, ALUToACC, ALU_Op, data, skip, address,
    output next_address, acc_out, alu_out, isZero, carry
  );
endinterface

// File: rtl/acc_alu_unit.sv
// acc_alu_unit: single-accumulator datapath with a combinational 4-op ALU
// (ADD/AND/XOR/PASS), a zero flag, and skip-if-zero next-address generation.
// Optional feature macro: ACC_CARRY_EN -- when defined, carry holds the ADD
// carry-out of the last ALU load; when undefined, carry is tied to 0.
module acc_alu_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              rst,
  acc_alu_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } alu_op_e;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] add_sum;
  logic [DATA_W-1:0] acc_next;
  logic              acc_zero;
  logic              skip_taken;
  logic [ADDR_W-1:0] addr_incr;
  alu_op_e           op;

  assign op = alu_op_e'(bus.ALU_Op);

`ifdef ACC_CARRY_EN
  logic [DATA_W:0] add_wide;
  logic            add_carry;
  logic            carry_q;

  assign add_wide  = {1'b0, acc} + {1'b0, bus.data};
  assign add_sum   = add_wide[DATA_W-1:0];
  assign add_carry = add_wide[DATA_W];
`else
  assign add_sum   = acc + bus.data;
`endif

  // ALU: operand A is the accumulator, operand B is the data bus
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = add_sum;
      OP_AND:  alu_res = acc & bus.data;
      OP_XOR:  alu_res = acc ^ bus.data;
      OP_PASS: alu_res = bus.data;
      default: alu_res = '0;
    endcase
  end

  // Accumulator load source: ALU result or raw data bus
  always_comb begin
    acc_next = bus.data;
    if (bus.ALUToACC) begin
      acc_next = alu_res;
    end
  end

  // Accumulator register; reset overrides any pending load
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (bus.regWrite) begin
      acc <= acc_next;
    end
  end

`ifdef ACC_CARRY_EN
  // Carry flag: captured on ALU ADD loads, cleared on any other load
  always_ff @(posedge clk) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (bus.regWrite) begin
      carry_q <= bus.ALUToACC && (op == OP_ADD) && add_carry;
    end
  end

  assign bus.carry = carry_q;
`else
  assign bus.carry = 1'b0;
`endif

  assign acc_zero   = (acc == '0);
  assign skip_taken = bus.skip && acc_zero;

  // Next address: +2 when skipping, else +1; wraps at ADDR_W bits
  always_comb begin
    addr_incr = ADDR_W'(1);
    if (skip_taken) begin
      addr_incr = ADDR_W'(2);
    end
  end

  assign bus.next_address = bus.address + addr_incr;
  assign bus.acc_out      = acc;
  assign bus.alu_out      = alu_res;
  assign bus.isZero       = acc_zero;

endmodule

// File: tb/tb_acc_alu_unit.sv
// tb_acc_alu_unit: directed checks of acc_alu_unit (reset, loads, ALU ops,
// skip/next-address wrap, reset priority). Carry expectations follow ACC_CARRY_EN.
module tb_acc_alu_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic carry_add_exp;

  acc_alu_unit_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  acc_alu_unit #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef ACC_CARRY_EN
    carry_add_exp = 1'b1;
`else
    carry_add_exp = 1'b0;
`endif
    rst          = 1'b0;
    bus.regWrite = 1'b0;
    bus.ALUToACC = 1'b0;
    bus.ALU_Op   = 2'b00;
    bus.data     = 8'h00;
    bus.skip     = 1'b0;
    bus.address  = 5'd0;

    // Reset
    tick();
    rst = 1'b1;
    tick();
    check("reset_acc",   32'(bus.acc_out), 32'h00);
    check("reset_zero",  32'(bus.isZero),  32'h1);
    check("reset_carry", 32'(bus.carry),   32'h0);

    // Direct load 0x3C
    bus.data = 8'h3C; bus.regWrite = 1'b1; bus.ALUToACC = 1'b0;
    tick();
    bus.regWrite = 1'b0;
    #1;
    check("load_acc",  32'(bus.acc_out), 32'h3C);
    check("load_zero", 32'(bus.isZero),  32'h0);

    // ALU sweep with acc=0x3C, data=0xF0
    bus.data = 8'hF0;
    bus.ALU_Op = 2'b00; #1; check("alu_add",  32'(bus.alu_out), 32'h2C);
    bus.ALU_Op = 2'b01; #1; check("alu_and",  32'(bus.alu_out), 32'h30);
    bus.ALU_Op = 2'b10; #1; check("alu_xor",  32'(bus.alu_out), 32'hCC);
    bus.ALU_Op = 2'b11; #1; check("alu_pass", 32'(bus.alu_out), 32'hF0);

    // ADD load: 0x3C + 0xF0 = 0x12C
    bus.ALU_Op = 2'b00; bus.ALUToACC = 1'b1; bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    #1;
    check("add_load_acc",   32'(bus.acc_out), 32'h2C);
    check("add_load_carry", 32'(bus.carry),   32'(carry_add_exp));

    // AND load clears carry: 0x2C & 0xF0 = 0x20
    bus.ALU_Op = 2'b01; bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    #1;
    check("and_load_acc",   32'(bus.acc_out), 32'h20);
    check("and_load_carry", 32'(bus.carry),   32'h0);

    // Hold: regWrite=0 with other controls active
    bus.data = 8'h55; bus.ALU_Op = 2'b11; bus.ALUToACC = 1'b1;
    tick();
    check("hold_acc", 32'(bus.acc_out), 32'h20);

    // Load 0 then skip checks
    bus.data = 8'h00; bus.ALUToACC = 1'b0; bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    bus.skip = 1'b1; bus.address = 5'd7;
    #1;
    check("zero_flag",      32'(bus.isZero),       32'h1);
    check("skip_taken",     32'(bus.next_address), 32'd9);
    bus.skip = 1'b0; #1;
    check("skip_off_zero",  32'(bus.next_address), 32'd8);

    bus.data = 8'h01; bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    bus.skip = 1'b1; #1;
    check("skip_nonzero",   32'(bus.next_address), 32'd8);
    bus.skip = 1'b0; #1;
    check("noskip",         32'(bus.next_address), 32'd8);

    // Wrap
    bus.address = 5'd31; bus.skip = 1'b0; #1;
    check("wrap_31_p1", 32'(bus.next_address), 32'd0);
    bus.skip = 1'b1; #1;
    check("wrap_31_nz", 32'(bus.next_address), 32'd0);
    bus.data = 8'h00; bus.regWrite = 1'b1;
    tick();
    bus.regWrite = 1'b0;
    #1;
    check("wrap_31_p2", 32'(bus.next_address), 32'd1);
    bus.address = 5'd30; #1;
    check("wrap_30_p2", 32'(bus.next_address), 32'd0);
    bus.skip = 1'b0; #1;
    check("addr_30_p1", 32'(bus.next_address), 32'd31);

    // Set acc and carry before testing reset priority: 0x5A + 0xF0 = 0x14A
    bus.data = 8'h5A; bus.ALUToACC = 1'b0; bus.regWrite = 1'b1;
    tick();
    bus.data = 8'hF0; bus.ALUToACC = 1'b1; bus.ALU_Op = 2'b00;
    tick();
    bus.regWrite = 1'b0;
    #1;
    check("pre_rst_acc",   32'(bus.acc_out), 32'h4A);
    check("pre_rst_carry", 32'(bus.carry),   32'(carry_add_exp));

    // Reset wins over a simultaneous load
    rst = 1'b0; bus.regWrite = 1'b1; bus.ALUToACC = 1'b0; bus.data = 8'hFF;
    tick();
    bus.address = 5'd3; bus.skip = 1'b1;
    #1;
    check("rst_prio_acc",   32'(bus.acc_out),      32'h00);
    check("rst_prio_carry", 32'(bus.carry),        32'h0);
    check("rst_prio_zero",  32'(bus.isZero),       32'h1);
    check("rst_next_addr",  32'(bus.next_address), 32'd5);

    // Release reset, data changes without regWrite
    rst = 1'b1; bus.regWrite = 1'b0; bus.data = 8'hAA;
    tick();
    bus.data = 8'h33;
    tick();
    check("post_rst_hold", 32'(bus.acc_out), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
